uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK, default 28000000, bus clock frequency in Hz.
REQ-002 Parameter BPS, default 115200, line bit rate.
REQ-003 Parameter PERIOD, default CLK/BPS (243), clock cycles per line bit.
REQ-004 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, max 16.
REQ-005 clk_bus  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 txdata  in  8  byte to enqueue.
REQ-008 txwr  in  1  enqueue strobe, sampled each clock.
REQ-009 cts  in  1  peer flow control from the far receiver's rts; 1 = hold off, 0 = send allowed; asynchronous.
REQ-010 tx  out  1  serial line, idle high.
REQ-011 txbusy  out  1  high while a frame is on the line.
REQ-012 txfull  out  1  FIFO holds DEPTH bytes.
REQ-013 txempty  out  1  FIFO holds 0 bytes.
REQ-014 txcount  out  5  current FIFO occupancy, 0..DEPTH.
REQ-015 txovf  out  1  one-cycle pulse when a write is dropped.

Function
REQ-016 cts passes through a 2-flop synchronizer; only the synchronized value (cts_s) is used.
REQ-017 On a clock with txwr=1 and txfull=0, txdata is written and txcount increments.
REQ-018 On a clock with txwr=1 and txfull=1, the byte is dropped, FIFO contents and txcount are unchanged, and txovf=1 for that cycle only.
REQ-019 txfull and txempty derive from registered txcount; a write while full is rejected even if a pop occurs in the same cycle.
REQ-020 A simultaneous push and pop leaves txcount unchanged; read and write pointers wrap modulo DEPTH.
REQ-021 The FSM has states IDLE, START, BIT and STOP.
REQ-022 In IDLE, if txempty=0 and cts_s=0, pop the head byte into the shift register, load the bit counter, enter START; else remain in IDLE with tx=1.
REQ-023 Each of START, BIT (x8) and STOP drives tx for exactly PERIOD clocks.
REQ-024 START drives tx=0.
REQ-025 BIT drives tx from shift register bit 0, LSB first, shifting right after each bit; transfer to STOP follows the 8th bit.
REQ-026 STOP drives tx=1.
REQ-027 On the last cycle of STOP, apply the IDLE start condition: if it holds, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
REQ-028 A frame spans exactly 10*PERIOD clocks.
REQ-029 tx falls on the second rising edge after the edge that sampled txwr into an empty FIFO, with cts_s=0 and the FSM in IDLE.
REQ-030 cts is checked only at frame start; cts_s rising mid-frame does not truncate or stretch the frame in progress.
REQ-031 txbusy=1 in START, BIT and STOP, and 0 in IDLE.
REQ-032 tx is a registered output and never glitches.

Reset
REQ-033 While rst_n=0: tx=1, txbusy=0, txcount=0, txempty=1, txfull=0, txovf=0, state=IDLE, pointers=0, synchronizer flops=1 (hold off).
REQ-034 Reset asserted mid-frame aborts the frame immediately (tx=1) and discards all queued bytes.
REQ-035 After reset release, no frame starts until cts_s=0, which takes at least 2 clocks.

Verification
REQ-036 cts=0, write 0x55 -> tx low 2 edges later; line reads 0,1,0,1,0,1,0,1,0,1, each 243 clocks; txbusy high for 2430 clocks.
REQ-037 Write 0xA5 then 0x3C on consecutive clocks, cts=0 -> two frames back-to-back, 4860 clocks total, with no idle cycle between the stop bit and the second start bit.
REQ-038 cts=1, write 17 bytes 0x00..0x10 -> txcount=16, txfull=1, txovf pulses once on the 17th write; release cts -> 0x00..0x0F sent in order, then txempty=1.
REQ-039 Raise cts during bit 3 of a frame -> frame completes unchanged; next queued byte held until cts=0 plus 2 synchronizer clocks.
REQ-040 Assert rst_n=0 during BIT with 3 bytes queued -> tx=1, txcount=0, txbusy=0 immediately; no further frames are sent after release.
REQ-041 FIFO at 15 bytes, push and pop on the same clock (STOP end) -> txcount stays 15; 20 further writes and pops wrap pointers with data order preserved.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it and cts flow control.
// Bytes written with txwr are queued and sent 8N1, LSB first, one line
// bit every PERIOD clocks. A new frame starts only while the synchronized
// cts is low and the FIFO is not empty. Frames run back-to-back when
// more data is waiting.
module uart_tx_fifo #(
  parameter int CLK    = 28000000,
  parameter int BPS    = 115200,
  parameter int PERIOD = CLK / BPS,
  parameter int DEPTH  = 16
) (
  input  logic       clk_bus,
  input  logic       rst_n,
  input  logic [7:0] txdata,
  input  logic       txwr,
  input  logic       cts,
  output logic       tx,
  output logic       txbusy,
  output logic       txfull,
  output logic       txempty,
  output logic [4:0] txcount,
  output logic       txovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(PERIOD - 1);
  localparam logic [4:0]    COUNT_FULL = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

  logic          cts_meta, cts_s;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop, start_ok;
  state_t        state, state_d;
  logic [CW-1:0] baud, baud_d;
  logic [2:0]    bitn, bitn_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_d;

  // Two-flop synchronizer for cts; resets to 1 so nothing is sent until
  // the peer's real level has propagated through.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= cts;
      cts_s    <= cts_meta;
    end
  end

  // Flags come from the registered count, so a write while full is refused
  // even if the FSM pops in the same cycle.
  assign txfull   = (txcount == COUNT_FULL);
  assign txempty  = (txcount == 5'd0);
  assign push     = txwr & ~txfull;
  assign start_ok = ~txempty & ~cts_s;
  assign txbusy   = (state != IDLE);

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone decide which entries are valid, and a reset on it would only
  // waste flops and block RAM inference.
  always_ff @(posedge clk_bus) begin
    if (push) mem[wptr] <= txdata;
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      txcount <= 5'd0;
      txovf   <= 1'b0;
    end else begin
      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   txcount <= txcount + 5'd1;
        2'b01:   txcount <= txcount - 5'd1;
        default: txcount <= txcount;
      endcase
      txovf <= txwr & txfull;
    end
  end

  // Transmit FSM: next state, datapath next values and the line level.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    baud_d  = baud;
    bitn_d  = bitn;
    shreg_d = shreg;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          shreg_d = mem[rptr];
          bitn_d  = 3'd0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud == BAUD_LAST) begin
          baud_d  = '0;
          state_d = BIT;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      BIT: begin
        tx_d = shreg[0];
        if (baud == BAUD_LAST) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg[7:1]};
          if (bitn == 3'd7) state_d = STOP;
          else              bitn_d  = bitn + 3'd1;
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud == BAUD_LAST) begin
          baud_d = '0;
          if (start_ok) begin
            pop     = 1'b1;
            shreg_d = mem[rptr];
            bitn_d  = 3'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, datapath registers and the registered serial line.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      baud  <= '0;
      bitn  <= 3'd0;
      shreg <= 8'd0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      baud  <= baud_d;
      bitn  <= bitn_d;
      shreg <= shreg_d;
      tx    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Stimulus queues the bytes it
// expects to see on the line; an independent monitor decodes tx and
// compares each received frame against the head of that queue.
module tb_uart_tx_fifo;

  localparam int P     = 16;
  localparam int FRAME = 10 * P;
  localparam int DEPTH = 16;

  logic       clk_bus = 1'b0;
  logic       rst_n;
  logic [7:0] txdata;
  logic       txwr;
  logic       cts;
  logic       tx;
  logic       txbusy;
  logic       txfull;
  logic       txempty;
  logic [4:0] txcount;
  logic       txovf;

  uart_tx_fifo #(
    .CLK(28000000), .BPS(115200), .PERIOD(P), .DEPTH(DEPTH)
  ) dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .txdata(txdata), .txwr(txwr),
    .cts(cts), .tx(tx), .txbusy(txbusy), .txfull(txfull),
    .txempty(txempty), .txcount(txcount), .txovf(txovf)
  );

  always #5 clk_bus = ~clk_bus;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  bit         mon_busy = 1'b0;
  int         mon_t = 0;
  int         mon_k = 0;
  int         frames = 0;
  logic [7:0] rx_b = 8'd0;
  logic [7:0] exp_b;

  always @(posedge clk_bus) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line monitor: detect the start edge, sample each bit at its centre.
  always @(negedge clk_bus) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_t    = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_t++;
      if (mon_t % P == P / 2) begin
        mon_k = mon_t / P;
        if (mon_k == 0) begin
          check("start_bit", tx, 0);
        end else if (mon_k <= 8) begin
          rx_b[mon_k-1] = tx;
        end else begin
          check("stop_bit", tx, 1);
          frames++;
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("frame_data", rx_b, exp_b);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_sent);
    txwr   = 1'b1;
    txdata = b;
    if (expect_sent) exp_q.push_back(b);
    tick();
    txwr = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !mon_busy && !txbusy) && n < budget) begin
      tick();
      n++;
    end
    check(name, (exp_q.size() == 0 && !mon_busy && !txbusy), 1);
  endtask

  task automatic busy_span(input string name, input int start_n, input int req);
    int busy_n = start_n;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (!txbusy) break;
      busy_n++;
    end
    check(name, busy_n, req);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_n;
    int n;
    int frames_before;

    rst_n  = 1'b0;
    cts    = 1'b1;
    txwr   = 1'b0;
    txdata = 8'h00;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", txbusy, 0);
    check("rst_count", txcount, 0);
    check("rst_empty", txempty, 1);
    check("rst_full", txfull, 0);
    check("rst_ovf", txovf, 0);
    rst_n = 1'b1;
    cts   = 1'b0;
    repeat (3) tick();
    check("idle_tx", tx, 1);

    // Single frame 0x55: latency, line pattern, busy length.
    write_byte(8'h55, 1);
    tick();
    check("lat_e1_tx", tx, 1);
    check("lat_e1_busy", txbusy, 1);
    tick();
    check("lat_e2_tx", tx, 0);
    busy_span("busy_len_1", 2, FRAME);
    wait_drain("drain_55", 2 * FRAME);

    // Two bytes on consecutive clocks: back-to-back frames.
    write_byte(8'hA5, 1);
    write_byte(8'h3C, 1);
    check("b2b_busy", txbusy, 1);
    busy_span("busy_len_2", 1, 2 * FRAME);
    wait_drain("drain_b2b", 2 * FRAME);
    check("b2b_gap", starts[starts.size()-1] - starts[starts.size()-2], FRAME);

    // Fill while held off, overflow on the 17th write, then drain.
    cts = 1'b1;
    repeat (3) tick();
    ovf_n = 0;
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(i), 1);
      ovf_n += int'(txovf);
    end
    check("full_count", txcount, 16);
    check("full_flag", txfull, 1);
    check("full_not_empty", txempty, 0);
    check("hold_busy", txbusy, 0);
    write_byte(8'h10, 0);
    ovf_n += int'(txovf);
    check("ovf_pulse", txovf, 1);
    check("ovf_count_kept", txcount, 16);
    tick();
    ovf_n += int'(txovf);
    check("ovf_one_cycle", txovf, 0);
    check("ovf_total", ovf_n, 1);
    cts = 1'b0;
    wait_drain("drain_fifo", 17 * FRAME + 50);
    check("empty_after", txempty, 1);
    check("count_after", txcount, 0);

    // cts raised during data bit 3: frame completes, next byte held.
    write_byte(8'h11, 1);
    write_byte(8'h22, 1);
    repeat (1 + 4 * P + P / 2) tick();
    cts = 1'b1;
    n = 0;
    while (txbusy && n < FRAME) begin
      tick();
      n++;
    end
    repeat (2 * P) tick();
    check("cts_hold_busy", txbusy, 0);
    check("cts_hold_count", txcount, 1);
    cts = 1'b0;
    tick();
    check("cts_sync_e1", txbusy, 0);
    tick();
    check("cts_sync_e2", txbusy, 0);
    tick();
    check("cts_sync_e3", txbusy, 1);
    wait_drain("drain_cts", 2 * FRAME);

    // Reset during BIT with 3 bytes queued.
    write_byte(8'hC1, 0);
    write_byte(8'hC2, 0);
    write_byte(8'hC3, 0);
    write_byte(8'hC4, 0);
    repeat (2 * P) tick();
    check("pre_reset_count", txcount, 3);
    frames_before = frames;
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", txbusy, 0);
    check("abort_count", txcount, 0);
    check("abort_empty", txempty, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3 * FRAME) tick();
    check("no_frames_after_reset", frames - frames_before, 0);
    check("post_reset_busy", txbusy, 0);

    // After release the synchronizer delays the first start by one clock.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    write_byte(8'h5A, 1);
    tick();
    check("rst_sync_e1", txbusy, 0);
    tick();
    check("rst_sync_e2", txbusy, 1);
    wait_drain("drain_5a", 2 * FRAME);

    // 15 queued, push at each STOP-end pop: count holds, pointers wrap.
    cts = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i), 1);
    cts = 1'b0;
    n = 0;
    while (!txbusy && n < 10) begin
      tick();
      n++;
    end
    check("wrap_start", txbusy, 1);
    check("wrap_count15", txcount, 15);
    for (int i = 0; i < 20; i++) begin
      repeat (FRAME - 1) tick();
      write_byte(8'h80 + 8'(i), 1);
      check("wrap_push_pop", txcount, 15);
    end
    wait_drain("drain_wrap", 17 * FRAME + 50);
    check("wrap_empty", txempty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
